// File: rtl/bus_pkg.sv
// Shared definitions for the wr/rd request bus: FSM state encoding, operation
// type and the default field widths used by both initiator and responder.
package bus_pkg;

  localparam int BUS_ADDR_W = 4;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_LEN_W  = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ACK      = 3'd1,
    WR_BURST = 3'd2,
    RD_WAIT  = 3'd3,
    RD_BURST = 3'd4
  } bus_state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } bus_op_e;

endpackage

// File: rtl/bus_responder_if.sv
// Request/response bundle between the bus initiator (master) and the
// responder (slave). Requests are held by the master until ready is seen.
interface bus_responder_if
  import bus_pkg::*;
#(
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int DATA_W = BUS_DATA_W,
  parameter int LEN_W  = BUS_LEN_W
);

  logic              io_wr;
  logic              io_rd;
  logic [ADDR_W-1:0] io_address;
  logic [LEN_W-1:0]  io_length;
  logic [DATA_W-1:0] io_wdata;
  logic              io_ready;
  logic              io_rddatavalid;
  logic [DATA_W-1:0] io_rdata;

  modport master (
    output io_wr, io_rd, io_address, io_length, io_wdata,
    input  io_ready, io_rddatavalid, io_rdata
  );

  modport slave (
    input  io_wr, io_rd, io_address, io_length, io_wdata,
    output io_ready, io_rddatavalid, io_rdata
  );

endinterface

// File: rtl/bus_regfile.sv
// 2^ADDR_W x DATA_W register-file memory: one synchronous write port and one
// combinational read port. Contents are deliberately never reset.
module bus_regfile
  import bus_pkg::*;
#(
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int DATA_W = BUS_DATA_W
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Synchronous write port.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bus_responder.sv
// Responder end of the wr/rd request bus. Accepts single and burst requests,
// acknowledges each with a one-cycle ready pulse, writes incoming beats into
// the register file and returns read beats qualified by rddatavalid.
module bus_responder
  import bus_pkg::*;
#(
  parameter int ADDR_W       = BUS_ADDR_W,
  parameter int DATA_W       = BUS_DATA_W,
  parameter int LEN_W        = BUS_LEN_W,
  parameter int READ_LATENCY = 1          // legal range 1..4
) (
  input  logic             clock,
  input  logic             reset,
  bus_responder_if.slave   bus
);

  localparam logic [2:0] ST_IDLE     = IDLE;
  localparam logic [2:0] ST_ACK      = ACK;
  localparam logic [2:0] ST_WR_BURST = WR_BURST;
  localparam logic [2:0] ST_RD_WAIT  = RD_WAIT;
  localparam logic [2:0] ST_RD_BURST = RD_BURST;

  // Last value of the latency counter before the first read beat is loaded.
  localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY - 1);

  logic [2:0]        state;
  logic [LEN_W-1:0]  cnt;
  logic [2:0]        lat_cnt;

  // Request fields captured at accept time (data, no reset needed).
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  bus_op_e           op_q;

  // Registered outputs.
  logic              ready_p1;
  logic              vld_p1;
  logic [DATA_W-1:0] rdata_p1;

  logic [ADDR_W-1:0] beat_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_we;
  logic              accept;

  // One adder serves both write and read bursts; cnt is 0 for the first beat,
  // so the same address also feeds the first read beat in ACK/RD_WAIT.
  assign beat_addr = addr_q + ADDR_W'(cnt);
  assign accept    = (state == ST_IDLE) && (bus.io_wr || bus.io_rd);

  // Write on the ready cycle and every following write-burst cycle; a reset
  // in the same cycle aborts the beat.
  assign mem_we = !reset &&
                  (((state == ST_ACK) && (op_q == OP_WR) && (len_q != '0)) ||
                   (state == ST_WR_BURST));

  bus_regfile #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_regfile (
    .clock (clock),
    .we    (mem_we),
    .waddr (beat_addr),
    .wdata (bus.io_wdata),
    .raddr (beat_addr),
    .rdata (mem_rdata)
  );

  // Capture the request on accept; write wins when wr and rd arrive together.
  always_ff @(posedge clock) begin
    if (accept) begin
      addr_q <= bus.io_address;
      len_q  <= bus.io_length;
      op_q   <= bus.io_wr ? OP_WR : OP_RD;
    end
  end

  // Request FSM, beat/latency counters and the registered output stage.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      lat_cnt  <= '0;
      ready_p1 <= 1'b0;
      vld_p1   <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      ready_p1 <= 1'b0;
      vld_p1   <= 1'b0;
      rdata_p1 <= '0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state    <= ST_ACK;
            ready_p1 <= 1'b1;
            cnt      <= '0;
          end
        end
        ST_ACK: begin
          if (len_q == '0) begin
            state <= ST_IDLE;
          end else if (op_q == OP_WR) begin
            if (len_q > LEN_W'(1)) begin
              state <= ST_WR_BURST;
              cnt   <= LEN_W'(1);
            end else begin
              state <= ST_IDLE;
            end
          end else if (READ_LATENCY == 1) begin
            // Latency 1: the first beat is loaded straight out of ACK.
            state    <= ST_RD_BURST;
            vld_p1   <= 1'b1;
            rdata_p1 <= mem_rdata;
            cnt      <= LEN_W'(1);
          end else begin
            state   <= ST_RD_WAIT;
            lat_cnt <= 3'd1;
          end
        end
        ST_WR_BURST: begin
          if (cnt == len_q - LEN_W'(1)) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + LEN_W'(1);
          end
        end
        ST_RD_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            state    <= ST_RD_BURST;
            vld_p1   <= 1'b1;
            rdata_p1 <= mem_rdata;
            cnt      <= LEN_W'(1);
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        ST_RD_BURST: begin
          // The beat visible this cycle is cnt-1; once cnt reaches len the
          // last beat is on the bus and the following cycle is idle.
          if (cnt == len_q) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            vld_p1   <= 1'b1;
            rdata_p1 <= mem_rdata;
            cnt      <= cnt + LEN_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.io_ready       = ready_p1;
  assign bus.io_rddatavalid = vld_p1;
  assign bus.io_rdata       = rdata_p1;

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder: instance A uses READ_LATENCY=1, instance B
// uses READ_LATENCY=3 for the busy/latency scenario.
module tb_bus_responder;
  import bus_pkg::*;

  logic clock = 1'b0;
  logic reset_a = 1'b1;
  logic reset_b = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  bus_responder_if #(.ADDR_W(4), .DATA_W(32), .LEN_W(4)) bus_a ();
  bus_responder_if #(.ADDR_W(4), .DATA_W(32), .LEN_W(4)) bus_b ();

  bus_responder #(.ADDR_W(4), .DATA_W(32), .LEN_W(4), .READ_LATENCY(1)) dut_a (
    .clock (clock),
    .reset (reset_a),
    .bus   (bus_a)
  );

  bus_responder #(.ADDR_W(4), .DATA_W(32), .LEN_W(4), .READ_LATENCY(3)) dut_b (
    .clock (clock),
    .reset (reset_b),
    .bus   (bus_b)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit sel, input logic wr, input logic rd,
                       input logic [3:0] addr, input logic [3:0] len,
                       input logic [31:0] wd);
    if (sel) begin
      bus_b.io_wr = wr; bus_b.io_rd = rd; bus_b.io_address = addr;
      bus_b.io_length = len; bus_b.io_wdata = wd;
    end else begin
      bus_a.io_wr = wr; bus_a.io_rd = rd; bus_a.io_address = addr;
      bus_a.io_length = len; bus_a.io_wdata = wd;
    end
  endtask

  task automatic set_wdata(input bit sel, input logic [31:0] wd);
    if (sel) bus_b.io_wdata = wd;
    else     bus_a.io_wdata = wd;
  endtask

  function automatic logic [31:0] get_ready(input bit sel);
    return {31'b0, sel ? bus_b.io_ready : bus_a.io_ready};
  endfunction

  function automatic logic [31:0] get_vld(input bit sel);
    return {31'b0, sel ? bus_b.io_rddatavalid : bus_a.io_rddatavalid};
  endfunction

  function automatic logic [31:0] get_rdata(input bit sel);
    return sel ? bus_b.io_rdata : bus_a.io_rdata;
  endfunction

  // Write burst with beat data base, base+1, ... on cycles T, T+1, ...
  task automatic wr_burst(input bit sel, input logic [3:0] addr, input logic [3:0] len,
                          input logic [31:0] base, input string tag);
    drive(sel, 1'b1, 1'b0, addr, len, base);
    tick();
    check({tag, "_rdy"}, get_ready(sel), 1);
    check({tag, "_novld"}, get_vld(sel), 0);
    drive(sel, 1'b0, 1'b0, addr, len, base);
    for (int i = 1; i < int'(len); i++) begin
      tick();
      set_wdata(sel, base + 32'(i));
    end
    tick();
    check({tag, "_rdy_low"}, get_ready(sel), 0);
  endtask

  // Read burst expecting beats base, base+1, ... starting at T+lat.
  task automatic rd_burst(input bit sel, input logic [3:0] addr, input logic [3:0] len,
                          input int lat, input logic [31:0] base, input string tag);
    drive(sel, 1'b0, 1'b1, addr, len, 32'h0);
    tick();
    check({tag, "_rdy"}, get_ready(sel), 1);
    drive(sel, 1'b0, 1'b0, addr, len, 32'h0);
    for (int c = 1; c < lat; c++) begin
      tick();
      check({tag, "_wait_vld"}, get_vld(sel), 0);
    end
    for (int i = 0; i < int'(len); i++) begin
      tick();
      check({tag, "_vld"}, get_vld(sel), 1);
      check({tag, "_data"}, get_rdata(sel), base + 32'(i));
    end
    tick();
    check({tag, "_end_vld"}, get_vld(sel), 0);
    check({tag, "_end_data"}, get_rdata(sel), 0);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 32'h0);
    tick();
    tick();
    check("rst_ready", get_ready(1'b0), 0);
    check("rst_vld", get_vld(1'b0), 0);
    check("rst_rdata", get_rdata(1'b0), 0);
    reset_a = 1'b0;
    reset_b = 1'b0;
    tick();

    // Single write then single read.
    drive(1'b0, 1'b1, 1'b0, 4'd4, 4'd1, 32'hA);
    check("single_req_cycle_rdy", get_ready(1'b0), 0);
    wr_burst(1'b0, 4'd4, 4'd1, 32'hA, "wr_single");
    rd_burst(1'b0, 4'd4, 4'd1, 1, 32'hA, "rd_single");

    // Burst write/read across the top of memory.
    wr_burst(1'b0, 4'hE, 4'd4, 32'd1, "wr_wrap");
    rd_burst(1'b0, 4'hE, 4'd4, 1, 32'd1, "rd_wrap");
    rd_burst(1'b0, 4'h0, 4'd1, 1, 32'd3, "rd_addr0");

    // Zero-length read: one ready pulse, no data, idle the next cycle.
    wr_burst(1'b0, 4'd5, 4'd1, 32'h77, "wr_five");
    drive(1'b0, 1'b0, 1'b1, 4'd5, 4'd0, 32'h0);
    tick();
    check("rz_rdy", get_ready(1'b0), 1);
    drive(1'b0, 1'b0, 1'b0, 4'd5, 4'd0, 32'h0);
    tick();
    check("rz_rdy_low", get_ready(1'b0), 0);
    check("rz_novld", get_vld(1'b0), 0);
    drive(1'b0, 1'b0, 1'b1, 4'd5, 4'd1, 32'h0);
    tick();
    check("rz_idle_reaccept", get_ready(1'b0), 1);
    drive(1'b0, 1'b0, 1'b0, 4'd5, 4'd1, 32'h0);
    tick();
    check("rz_next_vld", get_vld(1'b0), 1);
    check("rz_next_data", get_rdata(1'b0), 32'h77);
    tick();
    check("rz_next_end", get_vld(1'b0), 0);

    // Zero-length write leaves memory untouched.
    wr_burst(1'b0, 4'd5, 4'd0, 32'hDEAD, "wz");
    rd_burst(1'b0, 4'd5, 4'd1, 1, 32'h77, "rd_after_wz");

    // Simultaneous wr and rd: write wins, no read data.
    drive(1'b0, 1'b1, 1'b1, 4'd2, 4'd1, 32'h55);
    tick();
    check("both_rdy", get_ready(1'b0), 1);
    drive(1'b0, 1'b0, 1'b0, 4'd2, 4'd1, 32'h55);
    tick();
    check("both_novld1", get_vld(1'b0), 0);
    tick();
    check("both_novld2", get_vld(1'b0), 0);
    rd_burst(1'b0, 4'd2, 4'd1, 1, 32'h55, "rd_both");

    // Reset on beat 2 of an 8-beat read.
    wr_burst(1'b0, 4'd6, 4'd8, 32'h100, "wr_eight");
    drive(1'b0, 1'b0, 1'b1, 4'd6, 4'd8, 32'h0);
    tick();
    check("rr_rdy", get_ready(1'b0), 1);
    drive(1'b0, 1'b0, 1'b0, 4'd6, 4'd8, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rr_beat", get_rdata(1'b0), 32'h100 + 32'(i));
    end
    reset_a = 1'b1;
    tick();
    check("rr_rst_vld", get_vld(1'b0), 0);
    check("rr_rst_rdata", get_rdata(1'b0), 0);
    check("rr_rst_rdy", get_ready(1'b0), 0);
    reset_a = 1'b0;
    tick();
    check("rr_after_vld", get_vld(1'b0), 0);
    tick();
    check("rr_after_vld2", get_vld(1'b0), 0);
    rd_burst(1'b0, 4'd6, 4'd2, 1, 32'h100, "rd_kept");

    // READ_LATENCY=3 with a write request held during the read burst.
    wr_burst(1'b1, 4'd3, 4'd2, 32'h30, "b_wr");
    drive(1'b1, 1'b0, 1'b1, 4'd3, 4'd2, 32'h0);
    tick();
    check("b_rd_rdy", get_ready(1'b1), 1);
    drive(1'b1, 1'b1, 1'b0, 4'd9, 4'd1, 32'h99);
    for (int c = 1; c <= 5; c++) begin
      tick();
      check("b_busy_rdy", get_ready(1'b1), 0);
      check("b_vld", get_vld(1'b1), (c == 3 || c == 4) ? 32'd1 : 32'd0);
      check("b_data", get_rdata(1'b1), (c == 3) ? 32'h30 : (c == 4) ? 32'h31 : 32'h0);
    end
    tick();
    check("b_wr_rdy_late", get_ready(1'b1), 1);
    drive(1'b1, 1'b0, 1'b0, 4'd9, 4'd1, 32'h99);
    tick();
    check("b_wr_rdy_pulse", get_ready(1'b1), 0);
    rd_burst(1'b1, 4'd9, 4'd1, 3, 32'h99, "b_rd_new");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
